display_scanner: RTL and testbench

//  Time-multiplexes the four stopwatch BCD digits onto the shared 7-segment bus.

---
 rtl/display_scanner_if.sv | 33 +++
 rtl/display_scanner.sv | 106 ++++++++++
 tb/tb_display_scanner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// ============================================================================
// Module      : display_scanner_if
// Description : Digit/control inputs and strobe/digit outputs of the display
//               scanner, grouped as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface display_scanner_if;
  logic [3:0] minute_top_digit;
  logic [3:0] minute_bot_digit;
  logic [3:0] second_top_digit;
  logic [3:0] second_bot_digit;
  logic       adjust;
  logic       sel;
  logic [3:0] an;
  logic [3:0] digit;
  logic       blank;

  modport master (
    output minute_top_digit, minute_bot_digit, second_top_digit, second_bot_digit,
    output adjust, sel,
    input  an, digit, blank
  );

  modport slave (
    input  minute_top_digit, minute_bot_digit, second_top_digit, second_bot_digit,
    input  adjust, sel,
    output an, digit, blank
  );
endinterface

`default_nettype wire

// File: rtl/display_scanner.sv
// ============================================================================
// Module      : display_scanner
// Description : Scans four BCD digits onto a shared 7-segment bus with
//               active-low anode strobes and adjust-mode pair blinking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scanner #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  display_scanner_if.slave      bus
);

  localparam int              c_RW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int              c_BW    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_RW-1:0] c_RLAST = c_RW'(REFRESH_DIV - 1);
  localparam logic [c_RW-1:0] c_RONE  = c_RW'(1);
  localparam logic [c_BW-1:0] c_BLAST = c_BW'(BLINK_DIV - 1);
  localparam logic [c_BW-1:0] c_BONE  = c_BW'(1);

  logic [c_RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [c_BW-1:0] bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
  logic            adj_prev_q;
  logic [3:0]      an_q, an_d;
  logic [3:0]      digit_q, digit_d;
  logic            blank_q, blank_d;

  logic            w_tick;
  logic            w_rise;
  logic            w_bwrap;
  logic [3:0]      w_sel_digit;
  logic            w_invalid;
  logic            w_in_pair;
  logic            w_blink_off;

  // Scan and blink timebases
  always_comb begin
    w_tick  = (rcnt_q == c_RLAST);
    rcnt_d  = w_tick ? '0 : rcnt_q + c_RONE;
    idx_d   = w_tick ? idx_q + 2'd1 : idx_q;

    w_rise  = bus.adjust & ~adj_prev_q;
    w_bwrap = (bcnt_q == c_BLAST);
    bcnt_d  = bcnt_q + c_BONE;
    phase_d = phase_q;
    if (w_rise) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (w_bwrap) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Output uses the post-edge phase so a fresh adjust edge is visible at once
  // and each blink half-period lasts exactly BLINK_DIV output cycles.
  always_comb begin
    case (idx_q)
      2'd0:    w_sel_digit = bus.second_bot_digit;
      2'd1:    w_sel_digit = bus.second_top_digit;
      2'd2:    w_sel_digit = bus.minute_bot_digit;
      default: w_sel_digit = bus.minute_top_digit;
    endcase
    w_invalid   = (w_sel_digit > 4'd9);
    w_in_pair   = idx_q[1] ^ bus.sel;
    w_blink_off = bus.adjust & phase_d & w_in_pair;
    blank_d     = w_invalid | w_blink_off;
    digit_d     = w_sel_digit;
    an_d        = blank_d ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q     <= '0;
      idx_q      <= 2'd0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      adj_prev_q <= 1'b0;
      an_q       <= 4'b1111;
      digit_q    <= 4'd0;
      blank_q    <= 1'b1;
    end else begin
      rcnt_q     <= rcnt_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      adj_prev_q <= bus.adjust;
      an_q       <= an_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.digit = digit_q;
  assign bus.blank = blank_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scanner.sv
// ============================================================================
// Module      : tb_display_scanner
// Description : Directed plus randomized bench for display_scanner, checked
//               against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scanner;

  localparam int R = 4;
  localparam int B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_scanner_if bus ();

  display_scanner #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: edges since reset and edges since blink anchor
  int   n_since_rst = 0;
  int   k_blink     = 0;
  logic prev_adj    = 1'b0;

  logic [3:0] mt = 4'd0, mb = 4'd0, st = 4'd0, sb = 4'd0;
  logic       adj = 1'b0, sl = 1'b0;

  logic [3:0] exp_an, exp_digit;
  logic       exp_blank;

  task automatic model_edge();
    int         idx;
    logic [3:0] val;
    logic       ph, inpair;
    if (rst) begin
      n_since_rst = 0;
      k_blink     = 0;
      prev_adj    = 1'b0;
      exp_an      = 4'b1111;
      exp_digit   = 4'd0;
      exp_blank   = 1'b1;
    end else begin
      idx = (n_since_rst / R) % 4;
      n_since_rst++;
      if (adj && !prev_adj) k_blink = 0;
      else                  k_blink++;
      prev_adj = adj;
      ph = ((k_blink / B) % 2) == 1;
      case (idx)
        0:       val = sb;
        1:       val = st;
        2:       val = mb;
        default: val = mt;
      endcase
      inpair    = sl ? (idx < 2) : (idx >= 2);
      exp_digit = val;
      exp_blank = (val > 4'd9) || (adj && ph && inpair);
      exp_an    = exp_blank ? 4'b1111 : ~(4'b0001 << idx);
    end
  endtask

  task automatic step(input logic r);
    rst                  = r;
    bus.minute_top_digit = mt;
    bus.minute_bot_digit = mb;
    bus.second_top_digit = st;
    bus.second_bot_digit = sb;
    bus.adjust           = adj;
    bus.sel              = sl;
    model_edge();
    @(posedge clk);
    #1;
    tests++;
    assert (bus.an === exp_an) else begin
      fails++;
      $error("FAIL an: got %b expected %b at %0t", bus.an, exp_an, $time);
    end
    tests++;
    assert (bus.digit === exp_digit) else begin
      fails++;
      $error("FAIL digit: got %h expected %h at %0t", bus.digit, exp_digit, $time);
    end
    tests++;
    assert (bus.blank === exp_blank) else begin
      fails++;
      $error("FAIL blank: got %b expected %b at %0t", bus.blank, exp_blank, $time);
    end
  endtask

  initial begin
    // Reset, then a plain scan of 1,2,3,4
    mt = 4'd1; mb = 4'd2; st = 4'd3; sb = 4'd4;
    repeat (2) step(1'b1);
    tests++;
    assert (bus.an === 4'b1111 && bus.digit === 4'd0 && bus.blank === 1'b1) else begin
      fails++;
      $error("FAIL reset_state: got an=%b digit=%h blank=%b expected 1111/0/1",
             bus.an, bus.digit, bus.blank);
    end
    step(1'b0);
    tests++;
    assert (bus.an === 4'b1110 && bus.digit === 4'd4) else begin
      fails++;
      $error("FAIL first_slot: got an=%b digit=%h expected 1110/4", bus.an, bus.digit);
    end
    repeat (19) step(1'b0);

    // Invalid digit in idx0
    sb = 4'hA;
    repeat (16) step(1'b0);
    sb = 4'd4;

    // Blink minutes pair
    adj = 1'b1; sl = 1'b0;
    repeat (40) step(1'b0);

    // Re-arm adjust 3 clk into a blanked half-period
    adj = 1'b0; step(1'b0);
    adj = 1'b1; repeat (11) step(1'b0);
    adj = 1'b0; step(1'b0);
    adj = 1'b1; repeat (20) step(1'b0);

    // Switch blinking pair mid-period
    sl = 1'b1; repeat (20) step(1'b0);
    adj = 1'b0;

    // Reset pulse mid-scan at idx2
    step(1'b1);
    repeat (8) step(1'b0);
    step(1'b1);
    repeat (6) step(1'b0);

    // Mid-slot digit change
    sb = 4'd7; repeat (4) step(1'b0);

    // Randomized operation
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) mt = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) mb = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) st = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) sb = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 15) == 0) adj = ~adj;
      if ($urandom_range(0, 7) == 0)  sl  = ~sl;
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
